// File: rtl/rvx_uart_bus_bridge.sv
// UART debug initiator: 8N1 'W'/'R' command frames become single 32-bit register-bus transactions.
// Request pulses one clock after the last command byte's stop sample; the reply start bit follows the response capture by one clock.
module rvx_uart_bus_bridge #(
    parameter logic [31:0] CYCLES_PER_BAUD = 32'd868,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] rw_address,
    input  logic [31:0] read_data,
    output logic        read_request,
    input  logic        read_response,
    output logic [31:0] write_data,
    output logic [3:0]  write_strobe,
    output logic        write_request,
    input  logic        write_response,
    output logic        busy
);
    localparam logic [31:0] HALF_BAUD = CYCLES_PER_BAUD >> 1;
    localparam logic [7:0]  CMD_W = 8'h57;
    localparam logic [7:0]  CMD_R = 8'h52;

    typedef enum logic [2:0] {S_IDLE, S_GET_ADDR, S_GET_DATA, S_ISSUE, S_WAIT, S_SEND} state_t;
    state_t state, state_n;

    logic        rx_meta, rx_s;
    logic        rx_active, rx_vld;
    logic [31:0] rcnt;
    logic [3:0]  rbit;
    logic [7:0]  rsh, rx_byte;

    logic        cmd_write;
    logic [1:0]  bcnt;
    logic [31:0] tcnt;
    logic        resp_ok;

    logic        tx_active;
    logic [31:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_sh;
    logic [23:0] rep_dat;
    logic [1:0]  rep_left;
    logic        tx_last;
    logic [7:0]  rep_first;
    logic [23:0] rep_rest;
    logic [1:0]  rep_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver: rbit 0..7 are data bits, rbit 8 is the stop bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_active <= 1'b0;
            rcnt      <= 32'd0;
            rbit      <= 4'd0;
            rsh       <= 8'h00;
            rx_vld    <= 1'b0;
            rx_byte   <= 8'h00;
        end else begin
            rx_vld <= 1'b0;
            if (!rx_active) begin
                if (rx_s) begin
                    rcnt <= 32'd0;
                end else if (rcnt == HALF_BAUD - 32'd1) begin
                    rx_active <= 1'b1;
                    rcnt      <= 32'd0;
                    rbit      <= 4'd0;
                end else begin
                    rcnt <= rcnt + 32'd1;
                end
            end else if (rcnt == CYCLES_PER_BAUD - 32'd1) begin
                rcnt <= 32'd0;
                if (rbit == 4'd8) begin
                    rx_active <= 1'b0;
                    if (rx_s) begin
                        rx_vld  <= 1'b1;
                        rx_byte <= rsh;
                    end
                end else begin
                    rsh  <= {rx_s, rsh[7:1]};
                    rbit <= rbit + 4'd1;
                end
            end else begin
                rcnt <= rcnt + 32'd1;
            end
        end
    end

    assign resp_ok = cmd_write ? write_response : read_response;
    assign tx_last = tx_active && (tx_cnt == CYCLES_PER_BAUD - 32'd1) &&
                     (tx_bit == 4'd9) && (rep_left == 2'd0);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (rx_vld && (rx_byte == CMD_W || rx_byte == CMD_R)) state_n = S_GET_ADDR;
            S_GET_ADDR: if (rx_vld && bcnt == 2'd3) state_n = cmd_write ? S_GET_DATA : S_ISSUE;
            S_GET_DATA: if (rx_vld && bcnt == 2'd3) state_n = S_ISSUE;
            S_ISSUE:    state_n = S_WAIT;
            // A response on the final counted cycle wins over the timeout.
            S_WAIT:     if (resp_ok || tcnt == TIMEOUT_CYCLES - 32'd1) state_n = S_SEND;
            S_SEND:     if (tx_last) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rep_first = 8'h45;
        rep_rest  = 24'h0;
        rep_n     = 2'd0;
        if (resp_ok) begin
            if (cmd_write) begin
                rep_first = 8'h4B;
            end else begin
                rep_first = read_data[7:0];
                rep_rest  = read_data[31:8];
                rep_n     = 2'd3;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            uart_tx       <= 1'b1;
            rw_address    <= 32'd0;
            write_data    <= 32'd0;
            write_strobe  <= 4'h0;
            read_request  <= 1'b0;
            write_request <= 1'b0;
            cmd_write     <= 1'b0;
            bcnt          <= 2'd0;
            tcnt          <= 32'd0;
            tx_active     <= 1'b0;
            tx_cnt        <= 32'd0;
            tx_bit        <= 4'd0;
            tx_sh         <= 9'h1FF;
            rep_dat       <= 24'h0;
            rep_left      <= 2'd0;
        end else begin
            read_request  <= 1'b0;
            write_request <= 1'b0;
            tcnt <= (state == S_WAIT) ? tcnt + 32'd1 : 32'd0;

            if (state == S_IDLE && state_n == S_GET_ADDR) begin
                cmd_write <= (rx_byte == CMD_W);
                bcnt      <= 2'd0;
            end
            if (rx_vld && state == S_GET_ADDR) begin
                rw_address <= {rx_byte, rw_address[31:8]};
                bcnt       <= bcnt + 2'd1;
            end
            if (rx_vld && state == S_GET_DATA) begin
                write_data <= {rx_byte, write_data[31:8]};
                bcnt       <= bcnt + 2'd1;
            end
            if (state != S_ISSUE && state_n == S_ISSUE) begin
                read_request  <= !cmd_write;
                write_request <= cmd_write;
                write_strobe  <= cmd_write ? 4'hF : 4'h0;
            end

            // Transmitter: start bit goes out on the same edge that enters SEND.
            if (state == S_WAIT && state_n == S_SEND) begin
                write_strobe <= 4'h0;
                rep_dat      <= rep_rest;
                rep_left     <= rep_n;
                tx_sh        <= {1'b1, rep_first};
                uart_tx      <= 1'b0;
                tx_cnt       <= 32'd0;
                tx_bit       <= 4'd0;
                tx_active    <= 1'b1;
            end else if (tx_active) begin
                if (tx_cnt == CYCLES_PER_BAUD - 32'd1) begin
                    tx_cnt <= 32'd0;
                    if (tx_bit == 4'd9) begin
                        if (rep_left != 2'd0) begin
                            tx_sh    <= {1'b1, rep_dat[7:0]};
                            rep_dat  <= {8'h00, rep_dat[23:8]};
                            rep_left <= rep_left - 2'd1;
                            uart_tx  <= 1'b0;
                            tx_bit   <= 4'd0;
                        end else begin
                            tx_active <= 1'b0;
                        end
                    end else begin
                        uart_tx <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[8:1]};
                        tx_bit  <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: doc/rvx_uart_bus_bridge.md
Name: rvx_uart_bus_bridge

Overview:
- UART-driven bus initiator, used for debug and program loading. Receives 8N1 command frames on uart_rx and issues single 32-bit read/write transactions on the standard register bus as initiator, the opposite end of the peripherals' responder interface.
- Returns results on uart_tx.
- Sits between the host debug UART pins and the system bus crossbar's initiator port.

Parameters:
- CYCLES_PER_BAUD, 32'd868, clock cycles per UART bit; must be >= 4.
- TIMEOUT_CYCLES, 32'd1024, bus cycles to wait for read_response/write_response before reporting an error.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- uart_rx  input  1  serial in, idle high, asynchronous to clock
- uart_tx  output  1  serial out, idle high
- rw_address  output  32  transaction byte address
- read_data  input  32  read return data, valid when read_response=1
- read_request  output  1  one-cycle read request pulse
- read_response  input  1  read completion strobe
- write_data  output  32  write data
- write_strobe  output  4  byte enables, always 4'b1111 during writes
- write_request  output  1  one-cycle write request pulse
- write_response  input  1  write completion strobe
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, all flops): uart_tx=1; rw_address=0; write_data=0; write_strobe=0; read_request=0; write_request=0; busy=0; FSM in IDLE.
- uart_rx passes through a 2-flop synchronizer before use; reset value is 1.
- RX byte:
  - Start is detected when synced rx is low for CYCLES_PER_BAUD/2 consecutive cycles; a return to high before that restarts the search.
  - 8 data bits, LSB first, are then sampled every CYCLES_PER_BAUD cycles, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the FSM state is unchanged.
- TX byte: start(0), 8 data bits LSB first, stop(1), each bit held exactly CYCLES_PER_BAUD cycles. Back-to-back bytes have no idle gap.
- Command protocol (multi-byte fields are little-endian):
  - 0x57 'W', A0..A3, D0..D3: write D to A; replies 0x4B 'K'.
  - 0x52 'R', A0..A3: read A; replies D0..D3.
  - On timeout, the reply for either command is the single byte 0x45 'E'.
  - Any other byte received in IDLE is ignored, with no reply.
- FSM states:
  - IDLE: valid cmd -> GET_ADDR, byte counter = 0.
  - GET_ADDR: 4 bytes shifted into rw_address[7:0]..[31:24]. Then -> GET_DATA (W) or ISSUE (R).
  - GET_DATA: 4 bytes into write_data. Then -> ISSUE.
  - ISSUE: assert exactly one of read_request/write_request for exactly one cycle. write_strobe=4'b1111 for writes, 0 for reads. -> WAIT.
  - WAIT:
    - Timeout counter increments each cycle. A response of the matching type captures read_data (reads) -> SEND.
    - Counter reaching TIMEOUT_CYCLES -> SEND with 'E'.
    - A response arriving in the same cycle the counter hits the limit counts as success.
    - A response of the wrong type is ignored.
  - SEND: transmit the reply bytes. After the final stop bit completes -> IDLE.
- Field stability: rw_address, write_data and write_strobe stay stable from ISSUE until leaving WAIT. write_strobe returns to 0 on entry to SEND.
- No inter-byte timeout. Bytes received during ISSUE/WAIT/SEND are dropped, which gives half-duplex operation.
- Latency: request pulses on the first clock after the stop-bit sample of the last command byte. The TX start bit begins the clock after the response is captured.
- Reset mid-frame or mid-transaction aborts immediately: no pending request, and uart_tx returns high.

Test Plan (CYCLES_PER_BAUD=16, TIMEOUT_CYCLES=64, responder model with 1-cycle response):
- Send 57 10 00 00 80 EF BE AD DE -> single write_request pulse with rw_address=0x80000010, write_data=0xDEADBEEF, write_strobe=4'hF; uart_tx returns 0x4B.
- Send 52 04 00 00 80 with responder read_data=0x12345678 -> single read_request pulse at 0x80000004; uart_tx returns 78 56 34 12; busy falls after the last stop bit.
- Responder silent, send 52 00 00 00 00 -> after 64 cycles in WAIT, uart_tx returns 0x45 and no second request is issued.
- Send 0x41, then a byte with stop bit forced 0, then a valid write cmd -> the first two bytes produce no reply and no request; the write completes with 'K'.
- Response pulse arriving exactly on cycle 64 of WAIT -> success path; read data is returned, not 'E'.
- Assert reset during GET_DATA, then send a full read cmd -> no write is ever issued; the read completes normally and all outputs show reset values while reset is high.
